// File: rtl/blkram_pkg.sv
// Shared constants for the boot/stage2 block RAM and its arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package blkram_pkg;

    // Backed depth of the block RAM; upper address bits alias inside the RAM.
    localparam int BLKRAM_WORDS  = 512;
    localparam int BLKRAM_ADDR_W = 12;

    // Requester identities, also used to tag which port owns a pending read.
    typedef logic port_id_t;
    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_DMA = 1'b1;

endpackage

// File: rtl/blkram_starve_ctr.sv
// Counts consecutive cycles the loader port is refused; flags when it must win.
// Latency: force_grant is a pure function of the registered count (no same-cycle path).
// Backpressure: none; the counter only observes m1_valid and grant1.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   m1_valid      loader port is requesting
//   grant1        loader port is granted this cycle
//   force_grant   loader port has waited MAX_WAIT cycles and takes priority
module blkram_starve_ctr
    import blkram_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic m1_valid,
    input  logic grant1,
    output logic force_grant
);

    logic [3:0] wait_cnt;

    // A dropped request or a grant restarts the wait; otherwise count up and
    // hold at MAX_WAIT so the force stays asserted until the loader wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!m1_valid || grant1) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 4'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign force_grant = (wait_cnt == 4'(MAX_WAIT));

endmodule

// File: rtl/blkram_arbiter.sv
// Two-port arbiter for the single-port boot/stage2 block RAM (CPU fixed priority, loader anti-starved).
// Latency: grant/ready same cycle; read data returns exactly one cycle after the accepted read.
// Backpressure: a refused requester sees ready=0 and holds valid+payload until ready.
//
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   m0_* (CPU), m1_* (loader/DMA)  valid/we/addr/wdata in, ready/rvalid/rdata out
//   ram_*                          select, byte we, read strobe, address, write data to RAM;
//                                  ram_data_out is the RAM's registered read data
module blkram_arbiter
    import blkram_pkg::*;
#(
    parameter int ADDR_W   = BLKRAM_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_valid,
    input  logic [3:0]        m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ready,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,

    input  logic              m1_valid,
    input  logic [3:0]        m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ready,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,

    output logic              ram_select,
    output logic [3:0]        ram_we,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data_in,
    input  logic [31:0]       ram_data_out
);

    logic     grant0;
    logic     grant1;
    logic     force_grant;
    logic     rd_pending;
    port_id_t rd_owner;

    blkram_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .m1_valid    (m1_valid),
        .grant1      (grant1),
        .force_grant (force_grant)
    );

    // Reset gates the grants so nothing reaches the RAM while reset is high;
    // that also means a read requested during reset never produces rvalid.
    assign grant1   = !reset && m1_valid && (!m0_valid || force_grant);
    assign grant0   = !reset && m0_valid && !grant1;
    assign m0_ready = grant0;
    assign m1_ready = grant1;

    always_comb begin
        ram_select  = grant0 || grant1;
        ram_we      = '0;
        ram_rd      = 1'b0;
        ram_addr    = '0;
        ram_data_in = '0;
        if (grant1) begin
            ram_we      = m1_we;
            ram_rd      = (m1_we == 4'h0);
            ram_addr    = m1_addr;
            ram_data_in = m1_wdata;
        end else if (grant0) begin
            ram_we      = m0_we;
            ram_rd      = (m0_we == 4'h0);
            ram_addr    = m0_addr;
            ram_data_in = m0_wdata;
        end
    end

    // Remember who issued the read so the RAM's registered data is steered
    // back to that port only, one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= PORT_CPU;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
        end else begin
            rd_pending <= ram_rd;
            if (ram_rd) begin
                rd_owner <= grant1 ? PORT_DMA : PORT_CPU;
            end
            m0_rvalid <= ram_rd && !grant1;
            m1_rvalid <= ram_rd && grant1;
        end
    end

    assign m0_rdata = (rd_pending && rd_owner == PORT_CPU) ? ram_data_out : '0;
    assign m1_rdata = (rd_pending && rd_owner == PORT_DMA) ? ram_data_out : '0;

endmodule

// File: tb/tb_blkram_arbiter.sv
module tb_blkram_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [3:0]  m0_we, m1_we;
    logic [11:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_select, ram_rd;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;

    int checks = 0;
    int errors = 0;

    blkram_arbiter #(.ADDR_W(12), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_select(ram_select), .ram_we(ram_we), .ram_rd(ram_rd), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM model: 512 x 32, byte enables, registered read, upper bits alias.
    logic [31:0] mem [512];
    logic        pl_en;
    logic [8:0]  pl_addr;
    logic [31:0] pl_data;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_select) begin
            if (ram_we != 4'h0) mem[ram_addr[8:0]] <= merge(mem[ram_addr[8:0]], ram_data_in, ram_we);
            if (ram_rd) ram_data_out <= mem[ram_addr[8:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model state for the randomized phase.
    logic [31:0] ref_mem [512];
    int          mdl_wait;
    bit          exp_rv0, exp_rv1;
    logic [31:0] exp_d0, exp_d1;

    task automatic model_cycle(output bit g0, output bit g1);
        g1 = !reset && m1_valid && (!m0_valid || mdl_wait >= MAX_WAIT);
        g0 = !reset && m0_valid && !g1;
        chk("rnd_ready0", 32'(m0_ready), 32'(g0));
        chk("rnd_ready1", 32'(m1_ready), 32'(g1));
        chk("rnd_select", 32'(ram_select), 32'(g0 || g1));
        if (g1) begin
            chk("rnd_addr1", 32'(ram_addr), 32'(m1_addr));
            chk("rnd_we1", 32'(ram_we), 32'(m1_we));
            chk("rnd_rd1", 32'(ram_rd), 32'(m1_we == 4'h0));
            chk("rnd_wdata1", ram_data_in, m1_wdata);
        end else if (g0) begin
            chk("rnd_addr0", 32'(ram_addr), 32'(m0_addr));
            chk("rnd_we0", 32'(ram_we), 32'(m0_we));
            chk("rnd_rd0", 32'(ram_rd), 32'(m0_we == 4'h0));
            chk("rnd_wdata0", ram_data_in, m0_wdata);
        end else begin
            chk("rnd_idle_addr", 32'(ram_addr), 32'h0);
            chk("rnd_idle_we_rd", 32'({ram_we, ram_rd}), 32'h0);
        end
        chk("rnd_rvalid0", 32'(m0_rvalid), 32'(exp_rv0));
        chk("rnd_rvalid1", 32'(m1_rvalid), 32'(exp_rv1));
        if (exp_rv0) begin
            chk("rnd_rdata0", m0_rdata, exp_d0);
            chk("rnd_rdata1_nonowner", m1_rdata, 32'h0);
        end
        if (exp_rv1) begin
            chk("rnd_rdata1", m1_rdata, exp_d1);
            chk("rnd_rdata0_nonowner", m0_rdata, 32'h0);
        end
        // Effects of this cycle's access, visible next cycle.
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        if (g0) begin
            if (m0_we == 4'h0) begin exp_rv0 = 1'b1; exp_d0 = ref_mem[m0_addr[8:0]]; end
            else ref_mem[m0_addr[8:0]] = merge(ref_mem[m0_addr[8:0]], m0_wdata, m0_we);
        end
        if (g1) begin
            if (m1_we == 4'h0) begin exp_rv1 = 1'b1; exp_d1 = ref_mem[m1_addr[8:0]]; end
            else ref_mem[m1_addr[8:0]] = merge(ref_mem[m1_addr[8:0]], m1_wdata, m1_we);
        end
        if (reset || !m1_valid || g1) mdl_wait = 0;
        else if (mdl_wait < MAX_WAIT) mdl_wait++;
    endtask

    typedef struct {
        logic        rst;
        logic        v0; logic [3:0] we0; logic [11:0] a0; logic [31:0] d0;
        logic        v1; logic [3:0] we1; logic [11:0] a1; logic [31:0] d1;
        logic        r0, r1, sel, rv0, rv1;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vecs [20];

    initial begin
        bit g0, g1;
        reset = 1'b1;
        m0_valid = 1'b0; m0_we = 4'h0; m0_addr = 12'h0; m0_wdata = 32'h0;
        m1_valid = 1'b0; m1_we = 4'h0; m1_addr = 12'h0; m1_wdata = 32'h0;
        pl_en = 1'b1; pl_addr = 9'h0; pl_data = 32'h0;

        //            rst   v0    we0   a0       d0             v1    we1   a1       d1             r0    r1    sel   rv0   rv1   rd0            rd1
        vecs[0]  = '{1'b1, 1'b1, 4'h0, 12'h010, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b1, 4'h0, 12'h010, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 4'h3, 12'h020, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 4'h0, 12'h020, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'hAABB5678};
        vecs[7]  = '{1'b0, 1'b1, 4'h0, 12'h001, 32'h0,        1'b1, 4'h0, 12'h002, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[8]  = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 4'h0, 12'h002, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11111111, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h22222222};
        vecs[10] = '{1'b0, 1'b1, 4'h0, 12'h010, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 4'h0, 12'h001, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h11111111};
        vecs[13] = '{1'b1, 1'b1, 4'h0, 12'h001, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[14] = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[15] = '{1'b0, 1'b1, 4'hF, 12'h030, 32'hCAFEF00D, 1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[16] = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 4'h0, 12'h030, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[17] = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'hCAFEF00D};
        vecs[18] = '{1'b0, 1'b1, 4'h0, 12'h210, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[19] = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};

        // Preload the RAM model while reset is held.
        for (int k = 0; k < 512; k++) begin
            pl_addr = 9'(k);
            case (k)
                'h001:   pl_data = 32'h11111111;
                'h002:   pl_data = 32'h22222222;
                'h010:   pl_data = 32'hDEADBEEF;
                'h020:   pl_data = 32'hAABBCCDD;
                default: pl_data = $urandom;
            endcase
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        @(negedge clk);
        chk("reset_ready0", 32'(m0_ready), 32'h0);
        chk("reset_ready1", 32'(m1_ready), 32'h0);
        chk("reset_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'h0);
        @(posedge clk); #1;

        // Directed vectors, one clock each.
        for (int i = 0; i < 20; i++) begin
            reset    = vecs[i].rst;
            m0_valid = vecs[i].v0; m0_we = vecs[i].we0; m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
            m1_valid = vecs[i].v1; m1_we = vecs[i].we1; m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1;
            @(negedge clk);
            chk($sformatf("vec%0d_ready0", i), 32'(m0_ready), 32'(vecs[i].r0));
            chk($sformatf("vec%0d_ready1", i), 32'(m1_ready), 32'(vecs[i].r1));
            chk($sformatf("vec%0d_select", i), 32'(ram_select), 32'(vecs[i].sel));
            chk($sformatf("vec%0d_rvalid0", i), 32'(m0_rvalid), 32'(vecs[i].rv0));
            chk($sformatf("vec%0d_rvalid1", i), 32'(m1_rvalid), 32'(vecs[i].rv1));
            if (vecs[i].rv0 || vecs[i].rv1) begin
                chk($sformatf("vec%0d_rdata0", i), m0_rdata, vecs[i].rd0);
                chk($sformatf("vec%0d_rdata1", i), m1_rdata, vecs[i].rd1);
            end
            @(posedge clk); #1;
        end

        // Starvation: CPU hammers continuously, loader wins on exactly the 5th cycle.
        m0_valid = 1'b1; m0_we = 4'h0; m0_addr = 12'h001;
        m1_valid = 1'b1; m1_we = 4'h0; m1_addr = 12'h002;
        for (int i = 0; i < MAX_WAIT + 1; i++) begin
            @(negedge clk);
            chk($sformatf("starve%0d_ready0", i), 32'(m0_ready), 32'(i < MAX_WAIT));
            chk($sformatf("starve%0d_ready1", i), 32'(m1_ready), 32'(i == MAX_WAIT));
            @(posedge clk); #1;
        end
        chk("starve_wait_cnt_cleared", 32'(dut.u_starve.wait_cnt), 32'h0);
        m1_addr = 12'h003;
        @(negedge clk);
        chk("starve_resume_ready0", 32'(m0_ready), 32'h1);
        chk("starve_resume_ready1", 32'(m1_ready), 32'h0);
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        m0_valid = 1'b0; m1_valid = 1'b0; reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        for (int k = 0; k < 512; k++) ref_mem[k] = mem[k];
        mdl_wait = 0; exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_d0 = 32'h0; exp_d1 = 32'h0;
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(63, 0) == 0);
            @(negedge clk);
            model_cycle(g0, g1);
            @(posedge clk); #1;
            if (!m0_valid || g0) begin
                m0_valid = ($urandom_range(3, 0) != 0);
                m0_we    = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
                m0_addr  = 12'($urandom);
                m0_wdata = $urandom;
            end
            if (!m1_valid || g1) begin
                m1_valid = ($urandom_range(3, 0) != 0);
                m1_we    = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
                m1_addr  = 12'($urandom);
                m1_wdata = $urandom;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blkram_arbiter.md
Name: blkram_arbiter

Overview:
- Shares the single-port boot/stage2 block RAM (512 x 32, byte write enables, registered read) between two requesters.
- Port 0 is the CPU bus and has fixed priority. Port 1 is the loader/DMA engine.
- An anti-starvation counter forces a port 1 grant after a bounded wait.
- Issues at most one RAM access per cycle and routes the registered read data back to the port that issued the read.

Parameters:
- ADDR_W, 12, word address width on both ports and toward the RAM.
- MAX_WAIT, 4, consecutive cycles port 1 may be denied before it takes priority (range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_valid  in  1  port 0 request
- m0_we  in  4  port 0 byte write enables; 0 = read
- m0_addr  in  ADDR_W  port 0 word address
- m0_wdata  in  32  port 0 write data
- m0_ready  out  1  port 0 request accepted this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  32  port 0 read data
- m1_valid, m1_we, m1_addr, m1_wdata, m1_ready, m1_rvalid, m1_rdata: same as port 0, for port 1
- ram_select  out  1  RAM select
- ram_we  out  4  RAM byte write enables
- ram_rd  out  1  RAM read strobe
- ram_addr  out  ADDR_W  RAM word address
- ram_data_in  out  32  RAM write data
- ram_data_out  in  32  RAM registered read data

Behaviour:
- Reset is synchronous and active-high, on the single clock clk. While reset is high:
  - m0_ready, m1_ready, ram_select and ram_rd are 0, gated combinationally.
  - The registers m0_rvalid, m1_rvalid, rd_pending and wait_cnt are cleared on the clock edge.
  - rd_owner is cleared to 0.
- Grant (combinational, same cycle):
  - grant1 = m1_valid and (not m0_valid, or wait_cnt == MAX_WAIT).
  - grant0 = m0_valid and not grant1.
  - mN_ready = grantN.
  - A request completes in the cycle it is granted. A requester holds valid and its payload stable until it sees ready.
- RAM drive:
  - With a grant, ram_select = 1 and ram_addr, ram_data_in and ram_we come from the winner.
  - ram_rd = 1 only if the winner's we == 0.
  - With no grant, ram_select = 0, ram_rd = 0, ram_we = 0, and ram_addr and ram_data_in are 0.
- Write: accepted in cycle T. The RAM is updated at the end of cycle T. No rvalid is produced.
- Read: accepted in cycle T. rd_pending <= 1 and rd_owner <= winner.
  - In cycle T+1, m{rd_owner}_rvalid = 1 and rdata = ram_data_out.
  - Fixed latency of 1. Reads may issue back to back, one per cycle.
- rdata to the non-owner port is 0 and is don't-care when rvalid = 0. rvalid is a single-cycle pulse.
- Anti-starvation (wait_cnt, 4 bits):
  - Increments when m1_valid and not grant1, saturating at MAX_WAIT.
  - Clears when grant1, or when m1_valid = 0.
  - Continuous port 0 traffic therefore yields at least one port 1 grant every MAX_WAIT+1 cycles.
- Read-after-write:
  - A port 0 write at T followed by a port 1 read of the same address at T+1 returns the new data.
  - Same-cycle conflicts are impossible, because only one access is granted per cycle.
- Address range: only 512 words are backed. Upper address bits pass through unmodified, and the RAM aliases them.
- Reset mid-read: a read issued in the cycle reset asserts produces no rvalid.

Decomposition:
- Shared package (blkram_pkg):
  - BLKRAM_WORDS = 512
  - BLKRAM_ADDR_W = 12
  - a port_id constant pair (PORT_CPU = 0, PORT_DMA = 1)
- Natural sub-module: blkram_starve_ctr, holding the wait counter and the force-grant compare.
- The arbiter instantiates alongside blkram and does not contain it.

Test Plan:
- Single read: reset, then RAM word 0x010 = 0xDEADBEEF; m0 read of 0x010 -> m0_ready at T, m0_rvalid at T+1 with m0_rdata = 0xDEADBEEF, m1_rvalid = 0.
- Byte write merge: m1 writes we = 4'b0011, data 0x12345678 to 0x020 (old value 0xAABBCCDD); m1 then reads 0x020 -> 0xAABB5678.
- Contention: m0 and m1 both valid with reads at 0x001 and 0x002 -> m0 wins in cycle 0 and m1 waits.
- Starvation: m0_valid held high continuously with m1_valid high and MAX_WAIT = 4 -> m1_ready asserts in exactly the 5th cycle, wait_cnt is then 0, and m0 resumes the next cycle.
- Back-to-back ownership: m0 read in cycle T, m1 read in cycle T+1 -> m0_rvalid at T+1 and m1_rvalid at T+2, each with its own data and no cross-routing.
- Reset mid-operation: assert reset in the same cycle a read is granted -> no rvalid on either port at T+1; ready = 0 and ram_select = 0 throughout reset.
